// File: rtl/spi_telemetry_pkg.sv
// Shared state type and command-format constants for the SPI telemetry slave.
package spi_telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } spi_state_e;

  localparam int unsigned CMD_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned CNT_WIDTH  = 6;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = 7'h7F;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state of the synchronizer chain.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_telemetry_slave.sv
// SPI slave exposing snapshot telemetry channels and one control register.
// Build option: SPI_TELEMETRY_SLAVE_BURST_EN enables multi-word burst frames.
module spi_telemetry_slave
  import spi_telemetry_pkg::*;
#(
  parameter int N_CH       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                         SPI_TELEMETRY_SLAVE_CLOCK_50,
  input  logic                         SPI_TELEMETRY_SLAVE_RESET_InLow,
  input  logic                         SPI_TELEMETRY_SLAVE_SS_InLow,
  input  logic                         SPI_TELEMETRY_SLAVE_SCK_In,
  input  logic                         SPI_TELEMETRY_SLAVE_MOSI_In,
  input  logic [N_CH*DATA_WIDTH-1:0]   SPI_TELEMETRY_SLAVE_CH_InBus,
  output logic                         SPI_TELEMETRY_SLAVE_MISO_Out,
  output logic [DATA_WIDTH-1:0]        SPI_TELEMETRY_SLAVE_CTRL_OutBus,
  output logic                         SPI_TELEMETRY_SLAVE_WRSTROBE_Out,
  output logic                         SPI_TELEMETRY_SLAVE_BUSY_Out
);

  logic clk_s;
  logic rst_n_s;
  assign clk_s   = SPI_TELEMETRY_SLAVE_CLOCK_50;
  assign rst_n_s = SPI_TELEMETRY_SLAVE_RESET_InLow;

  logic ss_level_s, ss_rise_s, ss_fall_s;
  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_sync_edge u_sync_ss (
    .clk_i   (clk_s),
    .rst_ni  (rst_n_s),
    .async_i (SPI_TELEMETRY_SLAVE_SS_InLow),
    .level_o (ss_level_s),
    .rise_o  (ss_rise_s),
    .fall_o  (ss_fall_s)
  );

  spi_sync_edge u_sync_sck (
    .clk_i   (clk_s),
    .rst_ni  (rst_n_s),
    .async_i (SPI_TELEMETRY_SLAVE_SCK_In),
    .level_o (sck_level_s),
    .rise_o  (sck_rise_s),
    .fall_o  (sck_fall_s)
  );

  spi_sync_edge u_sync_mosi (
    .clk_i   (clk_s),
    .rst_ni  (rst_n_s),
    .async_i (SPI_TELEMETRY_SLAVE_MOSI_In),
    .level_o (mosi_s),
    .rise_o  (mosi_rise_s),
    .fall_o  (mosi_fall_s)
  );

  assign unused_s = ^{sck_level_s, mosi_rise_s, mosi_fall_s};

  // SCK edges only count while the slave is selected.
  logic lead_s, trail_s, sample_s, shift_s;
  assign lead_s   = (CPOL != 0) ? sck_fall_s : sck_rise_s;
  assign trail_s  = (CPOL != 0) ? sck_rise_s : sck_fall_s;
  assign sample_s = ((CPHA != 0) ? trail_s : lead_s) & ~ss_level_s;
  assign shift_s  = ((CPHA != 0) ? lead_s : trail_s) & ~ss_level_s;

  spi_state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CMD_WIDTH-2:0]       cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       rd_q, rd_d;
  logic [DATA_WIDTH-2:0]      rx_q, rx_d;
  logic [DATA_WIDTH-1:0]      tx_q, tx_d;
  logic                       miso_q, miso_d;
  logic [DATA_WIDTH-1:0]      ctrl_q, ctrl_d;
  logic                       strobe_q, strobe_d;
  logic                       busy_q, busy_d;
  logic [N_CH*DATA_WIDTH-1:0] snap_q, snap_d;
  logic [CMD_WIDTH-1:0]       cmd_full_s;
  logic [DATA_WIDTH-1:0]      rx_full_s;

  assign cmd_full_s = {cmd_q, mosi_s};
  assign rx_full_s  = {rx_q, mosi_s};

  function automatic logic [DATA_WIDTH-1:0] word_sel(
    input logic [ADDR_WIDTH-1:0]      addr,
    input logic [DATA_WIDTH-1:0]      ctrl,
    input logic [N_CH*DATA_WIDTH-1:0] snap
  );
    logic [DATA_WIDTH-1:0] w;
    w = (addr == CTRL_ADDR) ? ctrl : '0;
    for (int k = 0; k < N_CH; k++) begin
      w = (addr == ADDR_WIDTH'(k)) ? snap[k*DATA_WIDTH +: DATA_WIDTH] : w;
    end
    return w;
  endfunction

  // Frame sequencing plus command/data shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    ctrl_d   = ctrl_q;
    strobe_d = 1'b0;
    snap_d   = snap_q;
    if (ss_rise_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall_s) begin
            state_d = CMD;
            cnt_d   = '0;
            snap_d  = SPI_TELEMETRY_SLAVE_CH_InBus;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          miso_d = 1'b0;
          if (sample_s) begin
            cmd_d = cmd_full_s[CMD_WIDTH-2:0];
            if (cnt_q == CNT_WIDTH'(CMD_WIDTH - 1)) begin
              state_d = DATA;
              cnt_d   = '0;
              addr_d  = cmd_full_s[ADDR_WIDTH-1:0];
              rd_d    = cmd_full_s[RW_BIT];
              tx_d    = word_sel(addr_d, ctrl_q, snap_q);
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end else begin
            cmd_d = cmd_q;
          end
        end
        DATA: begin
          if (shift_s) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end else if (sample_s) begin
            rx_d = rx_full_s[DATA_WIDTH-2:0];
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
              cnt_d = '0;
              if (!rd_q && (addr_q == CTRL_ADDR)) begin
                ctrl_d   = rx_full_s;
                strobe_d = 1'b1;
              end else begin
                ctrl_d = ctrl_q;
              end
`ifdef SPI_TELEMETRY_SLAVE_BURST_EN
              // Channels walk and wrap; the control register and holes stay put.
              if (addr_q == ADDR_WIDTH'(N_CH - 1)) begin
                addr_d = '0;
              end else if (addr_q < ADDR_WIDTH'(N_CH - 1)) begin
                addr_d = addr_q + 7'd1;
              end else begin
                addr_d = addr_q;
              end
              tx_d = word_sel(addr_d, ctrl_d, snap_q);
`else
              state_d = HOLD;
              miso_d  = 1'b0;
`endif
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end else begin
            miso_d = miso_q;
          end
        end
        HOLD: begin
          state_d = HOLD;
          miso_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset wins over any SPI activity.
  always_ff @(posedge clk_s) begin
    if (!rst_n_s) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      rx_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      ctrl_q   <= CTRL_RESET;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      ctrl_q   <= ctrl_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      snap_q   <= snap_d;
    end
  end

  assign SPI_TELEMETRY_SLAVE_MISO_Out     = miso_q;
  assign SPI_TELEMETRY_SLAVE_CTRL_OutBus  = ctrl_q;
  assign SPI_TELEMETRY_SLAVE_WRSTROBE_Out = strobe_q;
  assign SPI_TELEMETRY_SLAVE_BUSY_Out     = busy_q;

endmodule

// File: tb/tb_spi_telemetry_slave.sv
// Bench driving a mode-0 and a mode-3 slave with identical frames and
// checking both against a word-level reference model.
module tb_spi_telemetry_slave;

  localparam int NCH = 16;
  localparam int DW  = 32;
  localparam logic [DW-1:0] CRST = 32'hA5A5_0001;
`ifdef SPI_TELEMETRY_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, ss, sck0, sck3, mosi;
  logic [DW-1:0] ch_arr [NCH];
  logic [NCH*DW-1:0] ch_bus;
  logic miso0, miso3, wrs0, wrs3, busy0, busy3;
  logic [DW-1:0] ctrl0, ctrl3;
  logic [DW-1:0] ctrl_m;
  int n_total = 0;
  int n_bad = 0;
  int str0 = 0;
  int str3 = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NCH; k++) ch_bus[k*DW +: DW] = ch_arr[k];
  end

  always @(posedge clk) begin
    if (wrs0) str0 <= str0 + 1;
    if (wrs3) str3 <= str3 + 1;
  end

  spi_telemetry_slave #(.N_CH(NCH), .DATA_WIDTH(DW), .CPOL(0), .CPHA(0), .CTRL_RESET(CRST)) dut0 (
    .SPI_TELEMETRY_SLAVE_CLOCK_50     (clk),
    .SPI_TELEMETRY_SLAVE_RESET_InLow  (rst_n),
    .SPI_TELEMETRY_SLAVE_SS_InLow     (ss),
    .SPI_TELEMETRY_SLAVE_SCK_In       (sck0),
    .SPI_TELEMETRY_SLAVE_MOSI_In      (mosi),
    .SPI_TELEMETRY_SLAVE_CH_InBus     (ch_bus),
    .SPI_TELEMETRY_SLAVE_MISO_Out     (miso0),
    .SPI_TELEMETRY_SLAVE_CTRL_OutBus  (ctrl0),
    .SPI_TELEMETRY_SLAVE_WRSTROBE_Out (wrs0),
    .SPI_TELEMETRY_SLAVE_BUSY_Out     (busy0)
  );

  spi_telemetry_slave #(.N_CH(NCH), .DATA_WIDTH(DW), .CPOL(1), .CPHA(1), .CTRL_RESET(CRST)) dut3 (
    .SPI_TELEMETRY_SLAVE_CLOCK_50     (clk),
    .SPI_TELEMETRY_SLAVE_RESET_InLow  (rst_n),
    .SPI_TELEMETRY_SLAVE_SS_InLow     (ss),
    .SPI_TELEMETRY_SLAVE_SCK_In       (sck3),
    .SPI_TELEMETRY_SLAVE_MOSI_In      (mosi),
    .SPI_TELEMETRY_SLAVE_CH_InBus     (ch_bus),
    .SPI_TELEMETRY_SLAVE_MISO_Out     (miso3),
    .SPI_TELEMETRY_SLAVE_CTRL_OutBus  (ctrl3),
    .SPI_TELEMETRY_SLAVE_WRSTROBE_Out (wrs3),
    .SPI_TELEMETRY_SLAVE_BUSY_Out     (busy3)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit: both clocks fall (shift), MOSI set, both rise (sample).
  task automatic xfer_bit(input logic b, output logic m0, output logic m3);
    sck0 = 1'b0;
    sck3 = 1'b0;
    tick(2);
    mosi = b;
    tick(3);
    sck0 = 1'b1;
    sck3 = 1'b1;
    m0 = miso0;
    m3 = miso3;
    tick(5);
  endtask

  // stop_at / rst_at: data-bit index at which SS rises early / reset pulses (-1 = never).
  task automatic spi_frame(input logic [7:0] cmd, input int nwords, input int stop_at,
                           input int rst_at, input logic [DW-1:0] wd0);
    logic [DW-1:0] snap [NCH];
    logic [DW-1:0] wd, exp_w, got0, got3;
    logic [6:0] addr;
    logic m0, m3, cmd_miso, was_rst, stop, rb;
    logic [5:0] bz;
    int nbits, exp_str, s0_base, s3_base;
    addr = cmd[6:0];
    nbits = 0;
    exp_str = 0;
    was_rst = 1'b0;
    stop = 1'b0;
    cmd_miso = 1'b0;
    got0 = '0;
    got3 = '0;
    for (int k = 0; k < NCH; k++) snap[k] = ch_arr[k];
    s0_base = str0;
    s3_base = str3;
    ss = 1'b0;
    tick(5);
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(cmd[i], m0, m3);
      cmd_miso = cmd_miso | m0 | m3;
    end
    check_val("cmd_miso", {63'd0, cmd_miso}, 64'd0);
    check_val("busy_frame", {62'd0, busy0, busy3}, 64'd3);
    for (int k = 0; k < NCH; k++) ch_arr[k] = ch_arr[k] + 32'd1;
    for (int w = 0; w < nwords && !stop; w++) begin
      wd = (w == 0) ? wd0 : $urandom;
      if (addr < 7'd16) exp_w = snap[addr[3:0]];
      else if (addr == 7'h7F) exp_w = ctrl_m;
      else exp_w = '0;
      if (!BURST && w > 0) exp_w = '0;
      for (int b = DW - 1; b >= 0 && !stop; b--) begin
        if (nbits == rst_at) begin
          rst_n = 1'b0;
          tick(1);
          check_val("rst_ctrl", {ctrl0, ctrl3}, {CRST, CRST});
          check_val("rst_outs", {58'd0, miso0, miso3, busy0, busy3, wrs0, wrs3}, 64'd0);
          rst_n = 1'b1;
          ctrl_m = CRST;
          was_rst = 1'b1;
          stop = 1'b1;
        end else if (nbits == stop_at) begin
          stop = 1'b1;
        end else begin
          rb = 1'($urandom_range(0, 1));
          xfer_bit(cmd[7] ? rb : wd[b], m0, m3);
          got0[b] = m0;
          got3[b] = m3;
          nbits++;
        end
      end
      if (!stop) begin
        if (cmd[7]) begin
          check_val("rd_mode0", {32'd0, got0}, {32'd0, exp_w});
          check_val("rd_mode3", {32'd0, got3}, {32'd0, exp_w});
        end else if (addr == 7'h7F && (BURST || w == 0)) begin
          ctrl_m = wd;
          exp_str++;
        end
        if (BURST && addr < 7'd16) addr = (addr == 7'd15) ? 7'd0 : addr + 7'd1;
      end
    end
    tick(5);
    sck0 = 1'b0;
    tick(5);
    ss = 1'b1;
    tick(1); bz[5:4] = {busy0, busy3};
    tick(1); bz[3:2] = {busy0, busy3};
    tick(1); bz[1:0] = {busy0, busy3};
    check_val("busy_fall", {58'd0, bz}, was_rst ? 64'd0 : 64'h3C);
    check_val("miso_idle", {62'd0, miso0, miso3}, 64'd0);
    check_val("strobes0", 64'(str0 - s0_base), 64'(exp_str));
    check_val("strobes3", 64'(str3 - s3_base), 64'(exp_str));
    check_val("ctrl", {ctrl0, ctrl3}, {ctrl_m, ctrl_m});
    tick(6);
  endtask

  initial begin
    logic [7:0] rcmd;
    int sel, nw, st;
    rst_n = 1'b0;
    ss = 1'b1;
    sck0 = 1'b0;
    sck3 = 1'b1;
    mosi = 1'b0;
    ctrl_m = CRST;
    for (int k = 0; k < NCH; k++) ch_arr[k] = 32'd0;
    tick(3);
    check_val("reset_ctrl", {ctrl0, ctrl3}, {CRST, CRST});
    check_val("reset_outs", {58'd0, miso0, miso3, busy0, busy3, wrs0, wrs3}, 64'd0);
    rst_n = 1'b1;
    tick(5);

    for (int k = 0; k < NCH; k++) ch_arr[k] = $urandom;
    ch_arr[3] = 32'hDEAD_BEEF;
    spi_frame(8'h83, 1, -1, -1, 32'd0);
    spi_frame(8'h7F, 1, -1, -1, 32'h0000_0005);
    ch_arr[0] = 32'h0000_0001;
    spi_frame(8'h80, 1, -1, -1, 32'd0);
    spi_frame(8'h7F, 1, 20, -1, $urandom);
    spi_frame(8'hFF, 1, -1, -1, 32'd0);
    spi_frame(8'h8F, 3, -1, -1, 32'd0);
    spi_frame(8'h7F, 1, -1, 10, $urandom);
    spi_frame(8'hFF, 1, -1, -1, 32'd0);

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NCH; k++) ch_arr[k] = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: rcmd = {1'b1, 7'($urandom_range(0, 15))};
        1: rcmd = 8'hFF;
        2: rcmd = {1'b1, 7'($urandom_range(16, 126))};
        3: rcmd = 8'h7F;
        default: rcmd = {1'b0, 7'($urandom_range(0, 126))};
      endcase
      nw = $urandom_range(1, 3);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      spi_frame(rcmd, nw, st, -1, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
